// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle between a producer, the pipeline stage and a consumer.
// master = side that drives the stage (upstream data, downstream ready).
// slave  = the stage itself.
interface pipe_stage_reg_if #(
    parameter int WIDTH = 192
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a one-entry skid buffer, stall/flush control
// and a saturating counter of cycles in which the consumer was starved.
// Bits [31:0] of the payload carry the PC and may survive a flush.
module pipe_stage_reg #(
    parameter int WIDTH            = 192,
    parameter int KEEP_PC_ON_FLUSH = 1,
    parameter int CNT_W            = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                flush,
    input  logic                cnt_clr,
    pipe_stage_reg_if.slave     bus,
    output logic [1:0]          occupancy,
    output logic [CNT_W-1:0]    starve_cnt
);

    logic [WIDTH-1:0] main_data;
    logic             main_valid;
    logic [WIDTH-1:0] skid_data;
    logic             skid_valid;
    logic             in_fire;
    logic             out_fire;

    // Handshake qualifiers; reset also blocks acceptance so nothing is taken while held.
    always_comb begin
        bus.in_ready = !skid_valid && !stall && !flush && !reset;
        in_fire      = bus.in_valid && bus.in_ready;
        out_fire     = main_valid && bus.out_ready && !stall && !flush;
        occupancy    = {1'b0, main_valid} + {1'b0, skid_valid};
    end

    assign bus.out_valid = main_valid;
    assign bus.out_data  = main_data;

    // Main/skid storage: flush wins over stall, stall freezes everything else.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_data  <= '0;
            main_valid <= 1'b0;
            skid_data  <= '0;
            skid_valid <= 1'b0;
        end else if (flush) begin
            main_valid              <= 1'b0;
            skid_valid              <= 1'b0;
            skid_data               <= '0;
            main_data[WIDTH-1:32]   <= '0;
            if (KEEP_PC_ON_FLUSH == 0) begin
                main_data[31:0] <= '0;
            end
        end else if (!stall) begin
            if (!skid_valid) begin
                if (!main_valid || out_fire) begin
                    // Payload only moves on an accepted entry so an idle stage
                    // keeps showing whatever PC a flush left behind.
                    main_valid <= in_fire;
                    if (in_fire) begin
                        main_data <= bus.in_data;
                    end
                end else if (in_fire) begin
                    skid_data  <= bus.in_data;
                    skid_valid <= 1'b1;
                end
            end else if (out_fire) begin
                main_data  <= skid_data;
                skid_valid <= 1'b0;
            end
        end
    end

    // Starvation counter: consumer ready but nothing to give it; saturates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (cnt_clr) begin
            starve_cnt <= '0;
        end else if (bus.out_ready && !main_valid && !stall && (starve_cnt != '1)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios plus a random phase, with a
// queue scoreboard tracking every accepted entry until it is consumed.
module tb_pipe_stage_reg;
    localparam int WIDTH = 192;
    localparam int CNT_W = 4;

    logic             clk;
    logic             reset;
    logic             stall;
    logic             flush;
    logic             cnt_clr;
    logic [1:0]       occupancy;
    logic [CNT_W-1:0] starve_cnt;

    int total;
    int bad;
    logic [WIDTH-1:0] sb_q[$];

    pipe_stage_reg_if #(.WIDTH(WIDTH)) bus ();

    pipe_stage_reg #(
        .WIDTH(WIDTH),
        .KEEP_PC_ON_FLUSH(1),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .stall(stall),
        .flush(flush),
        .cnt_clr(cnt_clr),
        .bus(bus.slave),
        .occupancy(occupancy),
        .starve_cnt(starve_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] mk(input logic [31:0] pc, input logic [31:0] tag);
        logic [WIDTH-1:0] v;
        v = {WIDTH{1'b0}};
        v[WIDTH-1:WIDTH-32] = tag;
        v[95:64]            = ~tag;
        v[31:0]             = pc;
        return v;
    endfunction

    // Scoreboard: at the falling edge inputs for the next edge are stable, so
    // the held-entry count and acceptance condition can be predicted here.
    always @(negedge clk) begin
        if (reset || flush) begin
            sb_q.delete();
        end else begin
            chk("occ_vs_sb", {190'b0, occupancy}, sb_q.size());
            chk("in_ready", {191'b0, bus.in_ready}, {191'b0, (sb_q.size() < 2) && !stall});
            if (bus.out_valid && bus.out_ready && !stall) begin
                if (sb_q.size() == 0) chk("sb_underflow", sb_q.size(), 1);
                else chk("sb_data", bus.out_data, sb_q.pop_front());
            end
            if (bus.in_valid && bus.in_ready) sb_q.push_back(bus.in_data);
        end
    end

    logic [WIDTH-1:0] a_v;
    logic [WIDTH-1:0] b_v;
    logic [WIDTH-1:0] c_v;
    logic [WIDTH-1:0] exp_v;

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        cnt_clr = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        #3;
        chk("rst_out_valid", {191'b0, bus.out_valid}, '0);
        chk("rst_out_data", bus.out_data, '0);
        chk("rst_occ", {190'b0, occupancy}, '0);
        chk("rst_starve", {188'b0, starve_cnt}, '0);
        chk("rst_in_ready", {191'b0, bus.in_ready}, '0);
        step();
        step();
        reset = 1'b0;

        // single entry latency
        a_v = mk(32'h3000, 32'hA0A0_0001);
        bus.in_valid = 1'b1;
        bus.in_data  = a_v;
        bus.out_ready = 1'b1;
        #1;
        chk("empty_in_ready", {191'b0, bus.in_ready}, {191'b0, 1'b1});
        step();
        bus.in_valid = 1'b0;
        chk("lat_out_valid", {191'b0, bus.out_valid}, {191'b0, 1'b1});
        chk("lat_out_data", bus.out_data, a_v);
        chk("lat_occ", {190'b0, occupancy}, 192'd1);
        step();
        chk("lat_drained", {190'b0, occupancy}, '0);

        // skid fill and drain in order, C held off until skid empties
        a_v = mk(32'h3000, 32'hA0A0_0002);
        b_v = mk(32'h3004, 32'hB0B0_0002);
        c_v = mk(32'h300C, 32'hC0C0_0002);
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = a_v;
        step();
        bus.in_data = b_v;
        step();
        bus.in_data = c_v;
        chk("skid_occ2", {190'b0, occupancy}, 192'd2);
        chk("skid_in_ready0", {191'b0, bus.in_ready}, '0);
        chk("skid_head_a", bus.out_data, a_v);
        bus.out_ready = 1'b1;
        step();
        chk("skid_then_b", bus.out_data, b_v);
        chk("skid_occ1", {190'b0, occupancy}, 192'd1);
        step();
        bus.in_valid = 1'b0;
        chk("skid_then_c", bus.out_data, c_v);
        step();
        chk("skid_empty", {190'b0, occupancy}, '0);

        // stall holds a full stage; stall on empty stage freezes starve_cnt
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = a_v;
        step();
        bus.in_data = b_v;
        step();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_hold_a", bus.out_data, a_v);
            chk("stall_occ2", {190'b0, occupancy}, 192'd2);
        end
        stall = 1'b0;
        step();
        step();
        step();
        chk("stall_drained", {190'b0, occupancy}, '0);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_starve_frozen", {188'b0, starve_cnt}, '0);
        end
        stall = 1'b0;

        // flush with stall over a full stage keeps only the PC of the head
        a_v = mk(32'h3008, 32'hDEAD_BEEF);
        b_v = mk(32'h300C, 32'hFEED_F00D);
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = a_v;
        step();
        bus.in_data = b_v;
        step();
        bus.in_valid = 1'b0;
        stall = 1'b1;
        flush = 1'b1;
        bus.out_ready = 1'b1;
        step();
        stall = 1'b0;
        flush = 1'b0;
        exp_v = '0;
        exp_v[31:0] = 32'h3008;
        chk("flush_out_valid", {191'b0, bus.out_valid}, '0);
        chk("flush_occ", {190'b0, occupancy}, '0);
        chk("flush_pc_kept", bus.out_data, exp_v);

        // starvation saturation, clear priority, flush does not touch the counter
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) step();
        chk("starve_sat", {188'b0, starve_cnt}, 192'd15);
        cnt_clr = 1'b1;
        step();
        chk("starve_clr", {188'b0, starve_cnt}, '0);
        cnt_clr = 1'b0;
        step();
        chk("starve_after_clr", {188'b0, starve_cnt}, 192'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("starve_flush", {188'b0, starve_cnt}, 192'd2);

        // random traffic with occasional stall and flush
        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_data   = mk($urandom(), $urandom());
            bus.out_ready = ($urandom_range(0, 2) != 0);
            stall         = ($urandom_range(0, 9) == 0);
            flush         = ($urandom_range(0, 29) == 0);
            step();
        end
        bus.in_valid = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("rand_sb_empty", sb_q.size(), '0);

        // reset between edges with the skid full
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = a_v;
        step();
        bus.in_data = b_v;
        step();
        bus.in_valid = 1'b0;
        chk("prerst_occ2", {190'b0, occupancy}, 192'd2);
        #2;
        reset = 1'b1;
        #1;
        chk("async_out_valid", {191'b0, bus.out_valid}, '0);
        chk("async_occ", {190'b0, occupancy}, '0);
        chk("async_starve", {188'b0, starve_cnt}, '0);
        chk("async_out_data", bus.out_data, '0);
        chk("async_in_ready", {191'b0, bus.in_ready}, '0);
        bus.in_valid = 1'b1;
        bus.in_data = c_v;
        bus.out_ready = 1'b1;
        step();
        chk("rst_hold_valid", {191'b0, bus.out_valid}, '0);
        chk("rst_hold_starve", {188'b0, starve_cnt}, '0);
        reset = 1'b0;
        step();
        bus.in_valid = 1'b0;
        chk("post_rst_valid", {191'b0, bus.out_valid}, {191'b0, 1'b1});
        chk("post_rst_data", bus.out_data, c_v);
        chk("post_rst_occ", {190'b0, occupancy}, 192'd1);
        step();
        step();
        chk("final_sb_empty", sb_q.size(), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
